// File: rtl/c7b_biu_arb_if.sv
// Bundle of the IFU, LSU and memory-port signals around the BIU arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface c7b_biu_arb_if;
    logic        ifu_req;
    logic [31:0] ifu_addr;
    logic        ifu_flush;
    logic        ifu_ack;
    logic        ifu_data_vld;

    logic        lsu_req;
    logic [31:0] lsu_addr;
    logic        lsu_wr;
    logic [63:0] lsu_wdata;
    logic [7:0]  lsu_wstrb;
    logic        lsu_ack;
    logic        lsu_data_vld;

    logic [63:0] rdata;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_ack;
    logic        mem_data_vld;
    logic [63:0] mem_rdata;

    logic        err_spurious;

    modport slave (
        input  ifu_req, ifu_addr, ifu_flush,
        output ifu_ack, ifu_data_vld,
        input  lsu_req, lsu_addr, lsu_wr, lsu_wdata, lsu_wstrb,
        output lsu_ack, lsu_data_vld,
        output rdata,
        output mem_req, mem_addr, mem_wr, mem_wdata, mem_wstrb,
        input  mem_ack, mem_data_vld, mem_rdata,
        output err_spurious
    );

    modport master (
        output ifu_req, ifu_addr, ifu_flush,
        input  ifu_ack, ifu_data_vld,
        output lsu_req, lsu_addr, lsu_wr, lsu_wdata, lsu_wstrb,
        input  lsu_ack, lsu_data_vld,
        input  rdata,
        input  mem_req, mem_addr, mem_wr, mem_wdata, mem_wstrb,
        output mem_ack, mem_data_vld, mem_rdata,
        input  err_spurious
    );
endinterface

// File: rtl/c7b_biu_arb.sv
// Shares the 64-bit memory port between IFU fetches and LSU accesses; an
// in-order owner FIFO routes each response beat back to its requester.
module c7b_biu_arb #(
    parameter int unsigned MAX_OUTST    = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           resetn,
    c7b_biu_arb_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
    localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic        OWN_IFU = 1'b1;
    localparam logic        OWN_LSU = 1'b0;

    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic             own_q  [MAX_OUTST];
    logic             kill_q [MAX_OUTST];
    logic             lock_vld_q;
    logic             lock_own_q;
    logic [STV_W-1:0] starve_q;
    logic             err_q;

    logic full_c;
    logic starved_c;
    logic lock_hit_c;
    logic sel_ifu_c;
    logic sel_lsu_c;
    logic mem_req_c;
    logic ifu_ack_c;
    logic lsu_ack_c;
    logic push_c;
    logic pop_c;
    logic head_own_c;
    logic head_kill_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Grant selection and response routing; a held lock only applies while its owner still requests
    always_comb begin
        full_c     = (count_q == CNT_W'(MAX_OUTST));
        starved_c  = bus.ifu_req && (starve_q == STV_W'(STARVE_LIMIT));
        lock_hit_c = lock_vld_q && ((lock_own_q == OWN_IFU) ? bus.ifu_req : bus.lsu_req);
        sel_ifu_c  = 1'b0;
        sel_lsu_c  = 1'b0;
        if (lock_hit_c) begin
            sel_ifu_c = (lock_own_q == OWN_IFU);
            sel_lsu_c = (lock_own_q == OWN_LSU);
        end else begin
            sel_lsu_c = bus.lsu_req && !starved_c;
            sel_ifu_c = bus.ifu_req && !sel_lsu_c;
        end
        mem_req_c   = (bus.ifu_req || bus.lsu_req) && !full_c && resetn;
        ifu_ack_c   = mem_req_c && bus.mem_ack && sel_ifu_c;
        lsu_ack_c   = mem_req_c && bus.mem_ack && sel_lsu_c;
        push_c      = ifu_ack_c || lsu_ack_c;
        pop_c       = resetn && bus.mem_data_vld && (count_q != '0);
        head_own_c  = own_q[rd_ptr_q];
        head_kill_c = kill_q[rd_ptr_q] || ((head_own_c == OWN_IFU) && bus.ifu_flush);
    end

    assign bus.mem_req      = mem_req_c;
    assign bus.mem_addr     = sel_lsu_c ? bus.lsu_addr : bus.ifu_addr;
    assign bus.mem_wr       = sel_lsu_c && bus.lsu_wr;
    assign bus.mem_wdata    = sel_lsu_c ? bus.lsu_wdata : '0;
    assign bus.mem_wstrb    = sel_lsu_c ? bus.lsu_wstrb : '0;
    assign bus.ifu_ack      = ifu_ack_c;
    assign bus.lsu_ack      = lsu_ack_c;
    assign bus.ifu_data_vld = pop_c && (head_own_c == OWN_IFU) && !head_kill_c;
    assign bus.lsu_data_vld = pop_c && (head_own_c == OWN_LSU);
    assign bus.rdata        = bus.mem_rdata;
    assign bus.err_spurious = err_q;

    // Lock, starvation counter, sticky error and the owner FIFO
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            lock_vld_q <= 1'b0;
            lock_own_q <= OWN_LSU;
            starve_q   <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < int'(MAX_OUTST); i++) begin
                own_q[i]  <= OWN_LSU;
                kill_q[i] <= 1'b0;
            end
        end else begin
            lock_vld_q <= mem_req_c && !bus.mem_ack;
            lock_own_q <= sel_ifu_c ? OWN_IFU : OWN_LSU;

            if (!bus.ifu_req || ifu_ack_c) begin
                starve_q <= '0;
            end else if (lsu_ack_c && (starve_q != STV_W'(STARVE_LIMIT))) begin
                starve_q <= starve_q + STV_W'(1);
            end

            if (bus.mem_data_vld && (count_q == '0)) begin
                err_q <= 1'b1;
            end

            // Free slots may be marked too; a push rewrites the kill bit
            for (int i = 0; i < int'(MAX_OUTST); i++) begin
                if (bus.ifu_flush && (own_q[i] == OWN_IFU)) begin
                    kill_q[i] <= 1'b1;
                end
            end

            if (push_c) begin
                own_q[wr_ptr_q]  <= sel_ifu_c ? OWN_IFU : OWN_LSU;
                kill_q[wr_ptr_q] <= sel_ifu_c && bus.ifu_flush;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop_c) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end

            if (push_c && !pop_c) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!push_c && pop_c) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule
